// File: rtl/fir_tap_scheduler_if.sv
// Handshake and address bus between the FIR tap scheduler and its
// surroundings (coefficient source, sample FIFO, RAMs, MAC datapath).
// The scheduler sits on the slave side; whoever drives PushCoef and
// fifo_empty uses the master side.
interface fir_tap_scheduler_if #(
  parameter int AW = 4
);
  logic          PushCoef;
  logic          fifo_empty;
  logic          fifoPullOut;
  logic          coef_we;
  logic [AW-1:0] coef_waddr;
  logic          samp_we;
  logic [AW-1:0] samp_waddr;
  logic [AW-1:0] coef_raddr;
  logic [AW-1:0] samp_raddr;
  logic [1:0]    multiplier_mux_sel;
  logic [1:0]    partialProductAccumulate_valid;
  logic          tap_zero;
  logic          finalAccumulateRounding_en;
  logic          PushOut;
  logic          coef_ready;
  logic          coef_drop;

  modport master (
    output PushCoef, fifo_empty,
    input  fifoPullOut, coef_we, coef_waddr, samp_we, samp_waddr,
           coef_raddr, samp_raddr, multiplier_mux_sel,
           partialProductAccumulate_valid, tap_zero,
           finalAccumulateRounding_en, PushOut, coef_ready, coef_drop
  );

  modport slave (
    input  PushCoef, fifo_empty,
    output fifoPullOut, coef_we, coef_waddr, samp_we, samp_waddr,
           coef_raddr, samp_raddr, multiplier_mux_sel,
           partialProductAccumulate_valid, tap_zero,
           finalAccumulateRounding_en, PushOut, coef_ready, coef_drop
  );
endinterface

// File: rtl/fir_tap_scheduler.sv
// FIR tap scheduler: loads a coefficient set, then for every input sample
// pulls it into a ring buffer and walks all NTAPS taps through a single
// multiply-accumulate, followed by a pipeline drain, a round/saturate
// strobe and a result-valid pulse. Every output is a flop except
// coef_drop, which flags a coefficient word arriving while busy.
module fir_tap_scheduler #(
  parameter int NTAPS = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  fir_tap_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT, PULL, MAC, DRAIN, ROUND, OUT
  } state_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(NTAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  localparam logic [AW-1:0] ONE_TAP  = AW'(1);

  state_t        r_state;
  logic [AW:0]   r_coefCnt;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_sampCnt;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_k;
  logic          r_coefReady;
  logic          r_fifoPull;
  logic          r_coefWe;
  logic [AW-1:0] r_coefWaddr;
  logic          r_sampWe;
  logic [AW-1:0] r_sampWaddr;
  logic [AW-1:0] r_coefRaddr;
  logic [AW-1:0] r_sampRaddr;
  logic [1:0]    r_muxSel;
  logic [1:0]    r_valid;
  logic          r_tapZero;
  logic          r_roundEn;
  logic          r_pushOut;

  logic [AW-1:0] w_nextK;
  logic          w_pullGo;
  logic          w_busy;
  logic          w_coefFirst;
  logic          w_coefNext;
  logic          w_enterPull;

  // A coefficient word restarts the load from IDLE, WAIT, or a LOAD that
  // has already collected a full set; a pending word always beats a pull.
  assign w_nextK     = r_k + ONE_TAP;
  assign w_pullGo    = r_coefReady && !bus.fifo_empty;
  assign w_busy      = (r_state == PULL) || (r_state == MAC) || (r_state == DRAIN) ||
                       (r_state == ROUND) || (r_state == OUT);
  assign w_coefFirst = bus.PushCoef &&
                       ((r_state == IDLE) || (r_state == WAIT) ||
                        ((r_state == LOAD) && (r_coefCnt == FULL_CNT)));
  assign w_coefNext  = bus.PushCoef && (r_state == LOAD) && (r_coefCnt != FULL_CNT);
  assign w_enterPull = ((r_state == WAIT) && !bus.PushCoef && w_pullGo) ||
                       ((r_state == OUT) && w_pullGo);

  // Scheduler state machine with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_coefCnt   <= '0;
      r_wptr      <= '0;
      r_sampCnt   <= '0;
      r_base      <= '0;
      r_k         <= '0;
      r_coefReady <= 1'b0;
      r_fifoPull  <= 1'b0;
      r_coefWe    <= 1'b0;
      r_coefWaddr <= '0;
      r_sampWe    <= 1'b0;
      r_sampWaddr <= '0;
      r_coefRaddr <= '0;
      r_sampRaddr <= '0;
      r_muxSel    <= 2'b00;
      r_valid     <= 2'b00;
      r_tapZero   <= 1'b0;
      r_roundEn   <= 1'b0;
      r_pushOut   <= 1'b0;
    end else begin
      r_fifoPull  <= 1'b0;
      r_sampWe    <= 1'b0;
      r_coefWe    <= 1'b0;
      r_muxSel    <= 2'b00;
      r_valid[0]  <= 1'b0;
      r_valid[1]  <= r_valid[0];
      r_tapZero   <= 1'b0;
      r_roundEn   <= 1'b0;
      r_pushOut   <= 1'b0;

      if (w_coefFirst) begin
        r_coefWe    <= 1'b1;
        r_coefWaddr <= '0;
        r_coefCnt   <= (AW+1)'(1);
        r_coefReady <= 1'b0;
      end else if (w_coefNext) begin
        r_coefWe    <= 1'b1;
        r_coefWaddr <= r_coefCnt[AW-1:0];
        r_coefCnt   <= r_coefCnt + (AW+1)'(1);
      end

      if (w_enterPull) begin
        r_fifoPull  <= 1'b1;
        r_sampWe    <= 1'b1;
        r_sampWaddr <= r_wptr;
        r_base      <= r_wptr;
        r_wptr      <= r_wptr + ONE_TAP;
        if (r_sampCnt != FULL_CNT) begin
          r_sampCnt <= r_sampCnt + (AW+1)'(1);
        end
      end

      unique case (r_state)
        IDLE: begin
          if (w_coefFirst) r_state <= LOAD;
        end
        LOAD: begin
          if ((r_coefCnt == FULL_CNT) && !bus.PushCoef) begin
            r_coefReady <= 1'b1;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.PushCoef) begin
            r_state <= LOAD;
          end else if (w_pullGo) begin
            r_state <= PULL;
          end
        end
        PULL: begin
          r_state     <= MAC;
          r_k         <= '0;
          r_coefRaddr <= '0;
          r_sampRaddr <= r_base;
          r_muxSel    <= 2'b01;
          r_valid[0]  <= 1'b1;
          r_tapZero   <= ((AW+1)'(0) >= r_sampCnt);
        end
        MAC: begin
          if (r_k == LAST_TAP) begin
            r_state <= DRAIN;
            r_k     <= '0;
          end else begin
            r_k         <= w_nextK;
            r_coefRaddr <= w_nextK;
            r_sampRaddr <= r_base - w_nextK;
            r_muxSel    <= 2'b10;
            r_valid[0]  <= 1'b1;
            r_tapZero   <= ({1'b0, w_nextK} >= r_sampCnt);
          end
        end
        DRAIN: begin
          if (r_k == ONE_TAP) begin
            r_state   <= ROUND;
            r_k       <= '0;
            r_roundEn <= 1'b1;
          end else begin
            r_k <= w_nextK;
          end
        end
        ROUND: begin
          r_state   <= OUT;
          r_pushOut <= 1'b1;
        end
        OUT: begin
          r_state <= w_pullGo ? PULL : WAIT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.fifoPullOut                    = r_fifoPull;
  assign bus.coef_we                        = r_coefWe;
  assign bus.coef_waddr                     = r_coefWaddr;
  assign bus.samp_we                        = r_sampWe;
  assign bus.samp_waddr                     = r_sampWaddr;
  assign bus.coef_raddr                     = r_coefRaddr;
  assign bus.samp_raddr                     = r_sampRaddr;
  assign bus.multiplier_mux_sel             = r_muxSel;
  assign bus.partialProductAccumulate_valid = r_valid;
  assign bus.tap_zero                       = r_tapZero;
  assign bus.finalAccumulateRounding_en     = r_roundEn;
  assign bus.PushOut                        = r_pushOut;
  assign bus.coef_ready                     = r_coefReady;
  assign bus.coef_drop                      = bus.PushCoef && w_busy;

endmodule
